neighbor_fetch_cntl: RTL

Downstream consumer of the neighbor-info stage: accepts per-node neighbor-info records (source node ID, neighbor-list start address, neighbor count), buffers them in a small FIFO, walks the neighbor-list SRAM, and emits one neighbor ID per cycle toward the feature-fetch FIFO. It drives the `full` back-pressure that the neighbor-info controller samples before producing the next record.

---
 rtl/neighbor_fetch_cntl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/neighbor_fetch_cntl.sv
// neighbor_fetch_cntl
//   Buffers neighbor-info records (source node, neighbor-list start address,
//   neighbor count) in a small first-word-fall-through FIFO. It then walks the
//   neighbor-list SRAM one word per cycle and emits one neighbor ID per beat
//   toward the feature-fetch FIFO.
//
// Ports
//   clk, reset                 single clock; asynchronous active-high reset
//   info_valid/_node_id/
//   _start_addr/_num_nb        record write from the neighbor-info stage
//   full                       back-pressure, asserted at occupancy >= DEPTH-1
//   overflow                   sticky flag for a record dropped at DEPTH
//   sram_cen, sram_a, sram_q   neighbor SRAM read port (cen active-low,
//                              q valid the cycle after the read)
//   out_full                   downstream almost-full
//   out_valid, out_src_id,
//   out_nb_id, out_last        neighbor beat toward feature fetch
//   busy                       FSM not idle or FIFO holding records
module neighbor_fetch_cntl #(
  parameter int FIFO_DEPTH = 4,
  parameter int NODE_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              info_valid,
  input  logic [NODE_W-1:0] info_node_id,
  input  logic [ADDR_W-1:0] info_start_addr,
  input  logic [CNT_W-1:0]  info_num_nb,
  output logic              full,
  output logic              overflow,
  output logic              sram_cen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [NODE_W-1:0] sram_q,
  input  logic              out_full,
  output logic              out_valid,
  output logic [NODE_W-1:0] out_src_id,
  output logic [NODE_W-1:0] out_nb_id,
  output logic              out_last,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  // One slot of slack: upstream registers its valid, so one more write can
  // land after it samples full.
  localparam logic [PTR_W:0] FULL_TH_C = (PTR_W+1)'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  // Record FIFO storage
  logic [NODE_W-1:0] r_fifo_node [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_fifo_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_occ;
  logic              r_overflow;

  // Walk state
  state_t            r_state, w_state_nxt;
  logic [NODE_W-1:0] r_cur_src;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_remaining;

  // Return pipe for the read issued last cycle
  logic              r_rd_pend;
  logic              r_rd_last;
  logic [NODE_W-1:0] r_rd_src;

  logic              w_empty, w_at_depth, w_pop, w_push, w_issue;
  logic [NODE_W-1:0] w_head_node;
  logic [ADDR_W-1:0] w_head_addr;
  logic [CNT_W-1:0]  w_head_cnt;

  assign w_empty     = (r_occ == '0);
  assign w_at_depth  = (r_occ == DEPTH_C);
  assign w_head_node = r_fifo_node[r_rptr];
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_cnt  = r_fifo_cnt[r_rptr];
  assign w_pop       = (r_state == IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a write at DEPTH still lands.
  assign w_push      = info_valid && (!w_at_depth || w_pop);
  assign w_issue     = (r_state == READ) && !out_full;

  // FIFO storage is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_node[r_wptr] <= info_node_id;
      r_fifo_addr[r_wptr] <= info_start_addr;
      r_fifo_cnt[r_wptr]  <= info_num_nb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + (PTR_W+1)'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - (PTR_W+1)'(1);
      if (info_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a zero-count record is popped and discarded in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_pop && (w_head_cnt != '0)) w_state_nxt = READ;
      READ: if (w_issue && (r_remaining == CNT_W'(1))) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sram_cen = !w_issue;
    sram_a   = w_issue ? r_cur_addr : '0;
    busy     = (r_state != IDLE) || !w_empty;
  end

  // Walk registers: loaded on pop, advanced on every issued read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_src   <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
    end else if (w_pop) begin
      r_cur_src   <= w_head_node;
      r_cur_addr  <= w_head_addr;
      r_remaining <= w_head_cnt;
    end else if (w_issue) begin
      r_cur_addr  <= r_cur_addr + ADDR_W'(1);
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  // Read return: beat emitted the cycle after issue regardless of out_full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_src  <= '0;
    end else begin
      r_rd_pend <= w_issue;
      r_rd_last <= w_issue && (r_remaining == CNT_W'(1));
      r_rd_src  <= r_cur_src;
    end
  end

  assign full       = (r_occ >= FULL_TH_C);
  assign overflow   = r_overflow;
  assign out_valid  = r_rd_pend;
  assign out_src_id = r_rd_pend ? r_rd_src : '0;
  assign out_nb_id  = r_rd_pend ? sram_q : '0;
  assign out_last   = r_rd_pend && r_rd_last;

endmodule
